memory_responder: RTL and testbench

MEMORY_RESPONDER -- requirements
Module: memory_responder

---
 rtl/memory_responder.sv | 147 ++++++++++++++
 tb/tb_memory_responder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/memory_responder.sv
// Dual-port word memory: instruction port is read-only, data port reads and writes.
// Define MEM_LATENCY_EN for per-port IDLE/WAIT/DONE latency FSMs; otherwise accesses are combinational.
`timescale 1ns/1ps
module memory_responder #(
    parameter int WORD_SIZE = 16,
    parameter int ADDR_BITS = 8,
    parameter int LATENCY   = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_readM,
    input  logic                 i_writeM,
    input  logic [WORD_SIZE-1:0] i_address,
    inout  wire  [WORD_SIZE-1:0] i_data,
    output logic                 i_ack,
    input  logic                 d_readM,
    input  logic                 d_writeM,
    input  logic [WORD_SIZE-1:0] d_address,
    inout  wire  [WORD_SIZE-1:0] d_data,
    output logic                 d_ack,
    output logic [WORD_SIZE-1:0] access_count
);
    localparam int DEPTH = 1 << ADDR_BITS;

    logic [WORD_SIZE-1:0] mem [DEPTH];
    logic [ADDR_BITS-1:0] i_idx_in, d_idx_in;
    logic                 i_oe, d_oe;
    logic [WORD_SIZE-1:0] i_rd, d_rd;
    logic                 mem_we;
    logic [ADDR_BITS-1:0] mem_waddr;
    logic [WORD_SIZE-1:0] mem_wdata;
    logic [1:0]           done_inc;
    logic                 unused_bits;

    assign i_idx_in = i_address[ADDR_BITS-1:0];
    assign d_idx_in = d_address[ADDR_BITS-1:0];
    assign i_data   = i_oe ? i_rd : {WORD_SIZE{1'bz}};
    assign d_data   = d_oe ? d_rd : {WORD_SIZE{1'bz}};

`ifdef MEM_LATENCY_EN
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);

    logic [1:0]           i_state, d_state;
    logic [3:0]           i_cnt, d_cnt;
    logic [ADDR_BITS-1:0] i_idx, d_idx;
    logic                 i_rd_op, d_rd_op, d_wr;
    logic [WORD_SIZE-1:0] i_rdata, d_rdata, d_wdata;
    logic                 i_fire, d_fire;

    assign i_fire = (i_state == S_WAIT) && (i_cnt == 4'd0);
    assign d_fire = (d_state == S_WAIT) && (d_cnt == 4'd0);

    // An i_writeM request runs the FSM and acks, but never touches the array.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            i_state <= S_IDLE;
            i_cnt   <= 4'd0;
            i_idx   <= '0;
            i_rd_op <= 1'b0;
            i_rdata <= '0;
        end else begin
            case (i_state)
                S_IDLE: if (i_readM || i_writeM) begin
                    i_idx   <= i_idx_in;
                    i_rd_op <= i_readM;
                    i_cnt   <= LAT_LOAD;
                    i_state <= S_WAIT;
                end
                S_WAIT: if (i_cnt != 4'd0) i_cnt <= i_cnt - 4'd1;
                        else begin
                            if (i_rd_op) i_rdata <= mem[i_idx];
                            i_state <= S_DONE;
                        end
                default: i_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d_state <= S_IDLE;
            d_cnt   <= 4'd0;
            d_idx   <= '0;
            d_rd_op <= 1'b0;
            d_wr    <= 1'b0;
            d_wdata <= '0;
            d_rdata <= '0;
        end else begin
            case (d_state)
                S_IDLE: if (d_readM || d_writeM) begin
                    d_idx   <= d_idx_in;
                    d_wr    <= d_writeM;
                    d_rd_op <= d_readM && !d_writeM;
                    d_wdata <= d_data;
                    d_cnt   <= LAT_LOAD;
                    d_state <= S_WAIT;
                end
                S_WAIT: if (d_cnt != 4'd0) d_cnt <= d_cnt - 4'd1;
                        else begin
                            if (d_rd_op) d_rdata <= mem[d_idx];
                            d_state <= S_DONE;
                        end
                default: d_state <= S_IDLE;
            endcase
        end
    end

    assign i_ack     = (i_state == S_DONE);
    assign d_ack     = (d_state == S_DONE);
    assign i_oe      = i_ack && i_rd_op;
    assign d_oe      = d_ack && d_rd_op;
    assign i_rd      = i_rdata;
    assign d_rd      = d_rdata;
    assign mem_we    = d_fire && d_wr;
    assign mem_waddr = d_idx;
    assign mem_wdata = d_wdata;
    assign done_inc  = {1'b0, i_fire} + {1'b0, d_fire};
    assign unused_bits = &{1'b0, i_address[WORD_SIZE-1:ADDR_BITS], d_address[WORD_SIZE-1:ADDR_BITS]};
`else
    // Everything is gated by reset so a held request cannot ack or write while reset is low.
    assign i_ack     = reset_n && (i_readM || i_writeM);
    assign d_ack     = reset_n && (d_readM || d_writeM);
    assign i_oe      = reset_n && i_readM;
    assign d_oe      = reset_n && d_readM && !d_writeM;
    assign i_rd      = mem[i_idx_in];
    assign d_rd      = mem[d_idx_in];
    assign mem_we    = reset_n && d_writeM;
    assign mem_waddr = d_idx_in;
    assign mem_wdata = d_data;
    assign done_inc  = {1'b0, i_ack} + {1'b0, d_ack};
    assign unused_bits = &{1'b0, i_address[WORD_SIZE-1:ADDR_BITS], d_address[WORD_SIZE-1:ADDR_BITS],
                           4'(LATENCY)};
`endif

    // Nonblocking array write: a same-edge instruction read still sees the old word.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) access_count <= '0;
        else          access_count <= access_count + WORD_SIZE'(done_inc);
    end
endmodule

// File: tb/tb_memory_responder.sv
// Self-checking bench for memory_responder; covers the combinational build by default
// and the latency FSM build when MEM_LATENCY_EN is defined.
`timescale 1ns/1ps
module tb_memory_responder;
    localparam int W = 16, AB = 8, LAT = 2, DEPTH = 256;

    logic          clk = 1'b0, reset_n = 1'b0;
    logic          i_readM = 0, i_writeM = 0, d_readM = 0, d_writeM = 0;
    logic [W-1:0]  i_address = '0, d_address = '0;
    wire  [W-1:0]  i_data, d_data;
    logic          i_ack, d_ack;
    logic [W-1:0]  access_count;
    logic          i_drv_en = 0, d_drv_en = 0;
    logic [W-1:0]  i_drv = '0, d_drv = '0;

    assign i_data = i_drv_en ? i_drv : {W{1'bz}};
    assign d_data = d_drv_en ? d_drv : {W{1'bz}};

    memory_responder #(.WORD_SIZE(W), .ADDR_BITS(AB), .LATENCY(LAT)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_readM(i_readM), .i_writeM(i_writeM), .i_address(i_address), .i_data(i_data), .i_ack(i_ack),
        .d_readM(d_readM), .d_writeM(d_writeM), .d_address(d_address), .d_data(d_data), .d_ack(d_ack),
        .access_count(access_count)
    );

    always #5 clk = ~clk;

    int           checks = 0, errors = 0;
    logic [W-1:0] exp_count = '0;
    logic [W-1:0] model [DEPTH];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // A high-Z bus reads back exactly what the bench drives onto it.
    task automatic probe_i(input string name);
        i_drv = 16'hA5C3; i_drv_en = 1'b1; #1;
        chk(name, i_data, 16'hA5C3);
        i_drv_en = 1'b0;
    endtask

    task automatic probe_d(input string name);
        d_drv = 16'h5A3C; d_drv_en = 1'b1; #1;
        chk(name, d_data, 16'h5A3C);
        d_drv_en = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

`ifndef MEM_LATENCY_EN
    typedef struct {
        logic ir, dr, dw;
        logic [W-1:0] ia, da, wd, ei, ed;
    } vec_t;
    vec_t tbl[8];

    // One combinational-mode cycle: inputs applied after an edge, outputs checked before the next.
    task automatic step(input logic ir, iw, dr, dw, input logic [W-1:0] ia, da, wd, ei, ed,
                        input string tag);
        i_readM = ir; i_writeM = iw; d_readM = dr; d_writeM = dw;
        i_address = ia; d_address = da; d_drv = wd; d_drv_en = dw;
        @(negedge clk);
        chk({tag, " i_ack"}, i_ack, ir | iw);
        chk({tag, " d_ack"}, d_ack, dr | dw);
        if (ir) chk({tag, " i_data"}, i_data, ei);
        else    probe_i({tag, " i_data hiz"});
        if (dw)      chk({tag, " d_data wr"}, d_data, wd);
        else if (dr) chk({tag, " d_data"}, d_data, ed);
        else         probe_d({tag, " d_data hiz"});
        if (dw) model[da[AB-1:0]] = wd;
        exp_count = exp_count + W'(ir | iw) + W'(dr | dw);
        @(posedge clk); #1;
        chk({tag, " count"}, access_count, exp_count);
        i_readM = 0; i_writeM = 0; d_readM = 0; d_writeM = 0; d_drv_en = 0;
    endtask
`else
    // One latency-mode transaction: capture edge, LATENCY quiet edges, one DONE cycle, back to idle.
    task automatic lat_txn(input logic ir, dr, dw, input logic [W-1:0] ia, da, wd, ei, ed,
                           input string tag);
        i_readM = ir; i_address = ia; d_readM = dr; d_writeM = dw; d_address = da;
        d_drv = wd; d_drv_en = dw;
        tick();
        i_readM = 0; d_readM = 0; d_writeM = 0; d_drv_en = 0;
        for (int k = 0; k < LAT; k++) begin
            chk({tag, " early ack"}, {i_ack, d_ack}, 2'b00);
            tick();
        end
        chk({tag, " i_ack"}, i_ack, ir);
        chk({tag, " d_ack"}, d_ack, dr | dw);
        if (ir) chk({tag, " i_data"}, i_data, ei);
        else    probe_i({tag, " i_data hiz"});
        if (dr && !dw) chk({tag, " d_data"}, d_data, ed);
        else           probe_d({tag, " d_data hiz"});
        exp_count = exp_count + W'(ir) + W'(dr | dw);
        chk({tag, " count"}, access_count, exp_count);
        tick();
        chk({tag, " ack drop"}, {i_ack, d_ack}, 2'b00);
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state, with requests asserted to show reset overrides them.
        #2;
        chk("reset i_ack", i_ack, 1'b0);
        chk("reset d_ack", d_ack, 1'b0);
        chk("reset count", access_count, '0);
        i_readM = 1; d_readM = 1; #1;
        chk("reset held acks", {i_ack, d_ack}, 2'b00);
        probe_i("reset i hiz");
        probe_d("reset d hiz");
        i_readM = 0; d_readM = 0;
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        tick();

`ifndef MEM_LATENCY_EN
        tbl[0] = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h0010, 16'h1234, 16'h0000, 16'h0000};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h0000, 16'h1234, 16'h0000};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 16'h0010, 16'h0105, 16'hBEEF, 16'h1234, 16'h0000};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 16'h0205, 16'h0005, 16'h0000, 16'hBEEF, 16'hBEEF};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h0020, 16'h0000, 16'h0000, 16'h0000};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 16'h0020, 16'h0020, 16'hBEEF, 16'h0000, 16'h0000};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 16'h0020, 16'h0030, 16'h7777, 16'hBEEF, 16'h0000};
        tbl[7] = '{1'b1, 1'b1, 1'b0, 16'h0030, 16'h0010, 16'h0000, 16'h7777, 16'h1234};
        for (int v = 0; v < 8; v++)
            step(tbl[v].ir, 1'b0, tbl[v].dr, tbl[v].dw, tbl[v].ia, tbl[v].da, tbl[v].wd,
                 tbl[v].ei, tbl[v].ed, $sformatf("vec%0d", v));

        // Reset with a write held across an edge: no ack, no bus, count cleared, array untouched.
        i_readM = 1; i_address = 16'h0030;
        d_writeM = 1; d_address = 16'h0030; d_drv = 16'h1111; d_drv_en = 1;
        reset_n = 1'b0; #1;
        exp_count = '0;
        chk("rst i_ack", i_ack, 1'b0);
        chk("rst d_ack", d_ack, 1'b0);
        chk("rst count", access_count, exp_count);
        chk("rst d bus", d_data, 16'h1111);
        i_readM = 0; probe_i("rst i hiz");
        tick();
        d_writeM = 0; d_drv_en = 0;
        @(negedge clk); reset_n = 1'b1;
        tick();
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0030, 16'h0, 16'h0, 16'h7777, 16'h0, "post-rst read");

        // Fill the whole array with known words, then random traffic against the model.
        for (int k = 0; k < DEPTH; k++) begin
            logic [W-1:0] a, wd;
            a = W'(k) | (W'($urandom_range(0, 255)) << AB);
            wd = W'($urandom);
            step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0, a, wd, 16'h0, 16'h0, "fill");
        end
        for (int n = 0; n < 300; n++) begin
            logic ir, iw, dr, dw;
            logic [W-1:0] ia, da, wd;
            ir = 1'($urandom_range(0, 1)); iw = ($urandom_range(0, 7) == 0);
            dr = 1'($urandom_range(0, 1)); dw = 1'($urandom_range(0, 1));
            ia = W'($urandom); da = W'($urandom); wd = W'($urandom);
            if (n % 4 == 0) da = ia;
            step(ir, iw, dr, dw, ia, da, wd, model[ia[AB-1:0]], model[da[AB-1:0]], "rand");
        end
`else
        lat_txn(1'b0, 1'b0, 1'b1, 16'h0000, 16'h0010, 16'h1234, 16'h0, 16'h0, "wr10");
        lat_txn(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h0000, 16'h1234, 16'h0, "rd10");
        lat_txn(1'b0, 1'b0, 1'b1, 16'h0000, 16'h0005, 16'h0055, 16'h0, 16'h0, "wr05");
        lat_txn(1'b0, 1'b0, 1'b1, 16'h0000, 16'h0006, 16'h0066, 16'h0, 16'h0, "wr06");
        lat_txn(1'b1, 1'b1, 1'b0, 16'h0005, 16'h0006, 16'h0000, 16'h0055, 16'h0066, "both");
        lat_txn(1'b0, 1'b0, 1'b1, 16'h0000, 16'h0020, 16'h0000, 16'h0, 16'h0, "wr20");
        lat_txn(1'b1, 1'b0, 1'b1, 16'h0020, 16'h0020, 16'hBEEF, 16'h0000, 16'h0, "wr/rd20");
        lat_txn(1'b1, 1'b0, 1'b0, 16'h0020, 16'h0000, 16'h0000, 16'hBEEF, 16'h0, "rd20");
        lat_txn(1'b0, 1'b1, 1'b1, 16'h0000, 16'h0105, 16'hCAFE, 16'h0, 16'h0, "rdwr105");
        lat_txn(1'b1, 1'b1, 1'b0, 16'h0205, 16'h0405, 16'h0000, 16'hCAFE, 16'hCAFE, "rd05");
        lat_txn(1'b0, 1'b0, 1'b1, 16'h0000, 16'h0030, 16'h3030, 16'h0, 16'h0, "wr30");

        // Reset while a write to 0x30 is waiting: it must be discarded.
        d_writeM = 1; d_address = 16'h0030; d_drv = 16'h9999; d_drv_en = 1;
        tick();
        d_writeM = 0; d_drv_en = 0;
        #2 reset_n = 1'b0; #1;
        exp_count = '0;
        chk("rst acks", {i_ack, d_ack}, 2'b00);
        chk("rst count", access_count, exp_count);
        probe_i("rst i hiz");
        probe_d("rst d hiz");
        tick(); tick();
        #2 reset_n = 1'b1;
        for (int k = 0; k <= LAT + 1; k++) begin
            tick();
            chk("rst no ack", {i_ack, d_ack}, 2'b00);
        end
        lat_txn(1'b1, 1'b0, 1'b0, 16'h0030, 16'h0000, 16'h0000, 16'h3030, 16'h0, "rd30 kept");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
